// File: rtl/hamming_scrubber_pkg.sv
// hamming_scrubber_pkg: shared types and constants for the SECDED(32,26) scrubber and decoder
package hamming_scrubber_pkg;
  localparam int DEFAULT_DEPTH = 32;
  localparam int DEFAULT_CNT_W = 8;
  localparam logic [31:0] CHK_MASK = 32'h0001_0116;
  localparam int CHK_POS [5] = '{1, 2, 4, 8, 16};
  typedef enum logic [2:0] {IDLE, READ, CHECK, WRITE, DONE} state_t;
  typedef enum logic [1:0] {CLEAN, SINGLE, DOUBLE} err_t;
endpackage

// File: rtl/hamming_secded_check.sv
// hamming_secded_check: combinational SECDED(32,26) syndrome, parity, classification and correction
module hamming_secded_check
  import hamming_scrubber_pkg::*;
(
  input  logic [31:0] word,
  output logic [4:0]  s,
  output logic        p,
  output err_t        cls,
  output logic [31:0] corrected
);
  always_comb begin
    s = '0;
    for (int i = 1; i < 32; i++)
      if (word[i]) s = s ^ 5'(i);
    p = ^word;
    cls = p ? SINGLE : (s != '0 ? DOUBLE : CLEAN);
    // s==0 with odd parity means the overall parity bit itself flipped
    corrected = p ? word ^ (32'd1 << s) : word;
  end
endmodule

// File: rtl/hamming_scrubber.sv
// hamming_scrubber: background sweep of the data memory, correcting single errors and logging double errors
module hamming_scrubber
  import hamming_scrubber_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  output logic [31:0]      mem_A,
  output logic             mem_WE,
  output logic [31:0]      mem_WD,
  input  logic [31:0]      mem_RD,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt,
  output logic             err_flag,
  output logic [31:0]      err_addr
);
  localparam int AW = $clog2(DEPTH);
  state_t state, nxt;
  logic [AW-1:0] addr;
  logic [31:0] word, corrected;
  logic [4:0] s;
  logic p, last, unused_chk;
  err_t cls;
  hamming_secded_check u_chk (
    .word(word),
    .s(s),
    .p(p),
    .cls(cls),
    .corrected(corrected)
  );
  assign unused_chk = ^{s, p};
  assign last = addr == AW'(DEPTH - 1);
  assign mem_A = 32'(addr);
  assign mem_WE = state == WRITE && !pause && !rst;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    nxt = state;
    if (!pause || state == IDLE)
      case (state)
        IDLE:    nxt = start ? READ : IDLE;
        READ:    nxt = CHECK;
        CHECK:   nxt = cls == SINGLE ? WRITE : (last ? DONE : READ);
        WRITE:   nxt = last ? DONE : READ;
        DONE:    nxt = IDLE;
        default: nxt = IDLE;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      word <= '0;
      mem_WD <= '0;
      corr_cnt <= '0;
      uncorr_cnt <= '0;
      err_flag <= 1'b0;
      err_addr <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        addr <= '0;
        corr_cnt <= '0;
        uncorr_cnt <= '0;
        err_flag <= 1'b0;
        err_addr <= '0;
      end
      // everything below freezes while the core owns the port
      if (!pause)
        case (state)
          READ: word <= mem_RD;
          CHECK: begin
            if (cls == SINGLE) mem_WD <= corrected;
            if (cls == DOUBLE) begin
              uncorr_cnt <= &uncorr_cnt ? uncorr_cnt : uncorr_cnt + 1'b1;
              if (!err_flag) begin
                err_flag <= 1'b1;
                err_addr <= 32'(addr);
              end
            end
            if (cls != SINGLE && !last) addr <= addr + 1'b1;
          end
          WRITE: begin
            corr_cnt <= &corr_cnt ? corr_cnt : corr_cnt + 1'b1;
            if (!last) addr <= addr + 1'b1;
          end
          default: ;
        endcase
    end
  end
endmodule
